seq_mult: RTL and testbench



---
 rtl/seq_mult.sv | 93 +++++++++
 tb/tb_seq_mult.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/seq_mult.sv
// Sequential shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH, one multiplier bit per clock.
// Define SEQ_MULT_SIGNED_EN for two's-complement operands and product.
module seq_mult #(
   parameter  int WIDTH = 4,
   localparam int CW    = $clog2(WIDTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   P
);
   localparam int DW = 2 * WIDTH;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] mcand, mplier;
   logic [DW-1:0]    acc, acc_next;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] a_in, b_in;

`ifdef SEQ_MULT_SIGNED_EN
   logic sign, sign_in;
   // Magnitudes are kept unsigned, so the most-negative value maps to 2^(WIDTH-1).
   assign a_in    = A[WIDTH-1] ? -A : A;
   assign b_in    = B[WIDTH-1] ? -B : B;
   assign sign_in = A[WIDTH-1] ^ B[WIDTH-1];
`else
   assign a_in = A;
   assign b_in = B;
`endif

   always_comb begin
      acc_next = acc;
      if (mplier[0]) acc_next = acc + (DW'(mcand) << count);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         P      <= '0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         count  <= '0;
`ifdef SEQ_MULT_SIGNED_EN
         sign   <= 1'b0;
`endif
      end else begin
         case (state)
            // DONE accepts a new start exactly like IDLE for back-to-back issue.
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  mcand  <= a_in;
                  mplier <= b_in;
                  acc    <= '0;
                  count  <= '0;
`ifdef SEQ_MULT_SIGNED_EN
                  sign   <= sign_in;
`endif
                  busy   <= 1'b1;
                  state  <= CALC;
               end else begin
                  state  <= IDLE;
               end
            end
            CALC: begin
               acc    <= acc_next;
               mplier <= mplier >> 1;
               count  <= count + 1'b1;
               if (count == CW'(WIDTH - 1)) begin
`ifdef SEQ_MULT_SIGNED_EN
                  P <= sign ? -acc_next : acc_next;
`else
                  P <= acc_next;
`endif
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_mult.sv
// Scoreboard bench for seq_mult: WIDTH=4 and WIDTH=8 instances, queue-based expected results.
module tb_seq_mult;
   typedef struct {
      logic [63:0] p;
      int          t;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start4 = 1'b0, start8 = 1'b0;
   logic [3:0] A4 = '0, B4 = '0;
   logic [7:0] A8 = '0, B8 = '0;
   logic       busy4, done4, busy8, done8;
   logic [7:0] P4;
   logic [15:0] P8;

   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;
   exp_t q4[$];
   exp_t q8[$];

   seq_mult #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .start(start4), .A(A4), .B(B4),
                             .busy(busy4), .done(done4), .P(P4));
   seq_mult #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .start(start8), .A(A8), .B(B8),
                             .busy(busy8), .done(done8), .P(P8));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference product straight from arithmetic on the operand values.
   function automatic logic [63:0] model(input int w, input longint a, input longint b);
      longint x, y;
      x = a & ((longint'(1) << w) - 1);
      y = b & ((longint'(1) << w) - 1);
`ifdef SEQ_MULT_SIGNED_EN
      if (x >= (longint'(1) << (w - 1))) x = x - (longint'(1) << w);
      if (y >= (longint'(1) << (w - 1))) y = y - (longint'(1) << w);
`endif
      return 64'((x * y) & ((longint'(1) << (2 * w)) - 1));
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Monitors: busy window and done/P/latency against queued expectations.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (q4.size() != 0 && cyc >= q4[0].t)
            chk("busy4", 64'(busy4), 64'(cyc < q4[0].t + 4));
         if (done4) begin
            if (q4.size() == 0) chk("done4_unexpected", 64'(done4), 64'd0);
            else begin
               e = q4.pop_front();
               chk("P4", 64'(P4), e.p);
               chk("lat4", 64'(cyc - e.t), 64'd4);
            end
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (q8.size() != 0 && cyc >= q8[0].t)
            chk("busy8", 64'(busy8), 64'(cyc < q8[0].t + 8));
         if (done8) begin
            if (q8.size() == 0) chk("done8_unexpected", 64'(done8), 64'd0);
            else begin
               e = q8.pop_front();
               chk("P8", 64'(P8), e.p);
               chk("lat8", 64'(cyc - e.t), 64'd8);
            end
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while ((q4.size() != 0 || q8.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         chk("timeout_q4", 64'(q4.size()), 64'd0);
         chk("timeout_q8", 64'(q8.size()), 64'd0);
         q4.delete();
         q8.delete();
      end
   endtask

   // One start pulse; operands are scrambled afterwards to prove they were captured.
   task automatic issue4(input int a, input int b);
      wait_idle();
      @(negedge clk);
      start4 = 1'b1; A4 = 4'(a); B4 = 4'(b);
      q4.push_back('{model(4, a, b), cyc + 1});
      @(negedge clk);
      start4 = 1'b0; A4 = 4'($urandom); B4 = 4'($urandom);
   endtask

   task automatic issue8(input int a, input int b);
      wait_idle();
      @(negedge clk);
      start8 = 1'b1; A8 = 8'(a); B8 = 8'(b);
      q8.push_back('{model(8, a, b), cyc + 1});
      @(negedge clk);
      start8 = 1'b0; A8 = 8'($urandom); B8 = 8'($urandom);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nf;
      repeat (2) @(negedge clk);
      chk("rst_P4", 64'(P4), 64'd0);
      chk("rst_busy4", 64'(busy4), 64'd0);
      chk("rst_done4", 64'(done4), 64'd0);
      chk("rst_P8", 64'(P8), 64'd0);
      chk("rst_busy8", 64'(busy8), 64'd0);
      chk("rst_done8", 64'(done8), 64'd0);
      rst = 1'b0;

      issue4(15, 12); issue4(10, 8); issue4(12, 5); issue4(2, 4);
      issue4(-8, 7);  issue4(-8, -8); issue4(-3, 5); issue4(0, 0);

      // start held high: a new accept every WIDTH+1 cycles, CALC-time changes ignored.
      wait_idle();
      nf = 0;
      repeat (22) begin
         @(negedge clk);
         start4 = 1'b1;
         if (cyc + 1 >= nf) begin
            A4 = 4'd15; B4 = 4'd15;
            q4.push_back('{model(4, 15, 15), cyc + 1});
            nf = cyc + 1 + 5;
         end else begin
            A4 = 4'($urandom); B4 = 4'($urandom);
         end
      end
      @(negedge clk);
      start4 = 1'b0;

      // Abort mid-operation, then a fresh start must still work.
      issue4(13, 11);
      @(negedge clk);
      rst = 1'b1;
      q4.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("abort_P4", 64'(P4), 64'd0);
      chk("abort_busy4", 64'(busy4), 64'd0);
      chk("abort_done4", 64'(done4), 64'd0);
      @(negedge clk);
      chk("abort_idle_busy4", 64'(busy4), 64'd0);
      issue4(13, 11);

      issue8(255, 255); issue8(0, 200); issue8(128, 128); issue8(-1, 2);

      repeat (15) begin
         issue4(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
         issue8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      end

      wait_idle();
      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
